// File: rtl/rotated_sprite_engine.sv
// rotated_sprite_engine
//   Per-pixel inverse-rotation sprite engine for the VGA overlay path. Each scan
//   coordinate is mapped back into sprite space with the active pose, the sprite ROM
//   is addressed, and a pixel-aligned draw flag plus RGB come out p_rom_latency+4
//   clocks after the coordinate was sampled. One pixel per clock, no stalls.
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   VGA_X, VGA_Y           unsigned scan coordinate, new value every clock
//   frame_start            one-cycle pulse in vertical blanking; swaps in a pending pose
//   pose_valid/pose_ready  pose offer handshake (ready while nothing is pending)
//   pose_x, pose_y         sprite origin
//   pose_cos, pose_sin     signed fixed point, p_frac_bits fraction bits
//   pose_en, pose_key_en   sprite enable, colour-key transparency enable
//   rom_addr, rom_q        sprite ROM address out, {R,G,B} data back
//   pose_applied           one-cycle pulse when a pending pose becomes active
//   draw_image, image_RGB  pixel belongs to the sprite, its colour (0 when not drawn)

module rotated_sprite_engine #(
  parameter int unsigned p_image_width  = 80,
  parameter int unsigned p_image_height = 480,
  parameter int unsigned p_frac_bits    = 8,
  parameter int unsigned p_rom_latency  = 2,
  parameter int unsigned p_addr_width   = 16,
  parameter logic [23:0] p_key_color    = 24'hFF00FF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [10:0]              VGA_X,
  input  logic [10:0]              VGA_Y,
  input  logic                     frame_start,
  input  logic                     pose_valid,
  output logic                     pose_ready,
  input  logic [10:0]              pose_x,
  input  logic [10:0]              pose_y,
  input  logic [p_frac_bits+1:0]   pose_cos,
  input  logic [p_frac_bits+1:0]   pose_sin,
  input  logic                     pose_en,
  input  logic                     pose_key_en,
  output logic [p_addr_width-1:0]  rom_addr,
  input  logic [23:0]              rom_q,
  output logic                     pose_applied,
  output logic                     draw_image,
  output logic [7:0]               image_R,
  output logic [7:0]               image_G,
  output logic [7:0]               image_B
);

  localparam int unsigned TrigW = p_frac_bits + 2;
  localparam int unsigned ProdW = 12 + TrigW;
  localparam int unsigned SumW  = ProdW + 1;
  localparam logic signed [31:0] WidthS  = 32'(p_image_width);
  localparam logic signed [31:0] HeightS = 32'(p_image_height);
  localparam logic [TrigW-1:0]   CosOne  = TrigW'(1) << p_frac_bits;

  // ---------------------------------------------------------------------------
  // Pose storage: one pending slot, swapped into the active set on frame_start
  // ---------------------------------------------------------------------------
  logic             pend_valid_q;
  logic [10:0]      pend_x_q, pend_y_q;
  logic [TrigW-1:0] pend_cos_q, pend_sin_q;
  logic             pend_en_q, pend_key_q;

  logic [10:0]      act_x_q, act_y_q;
  logic [TrigW-1:0] act_cos_q, act_sin_q;
  logic             act_en_q, act_key_q;
  logic             applied_q;

  logic accept, swap;

  assign pose_ready = !pend_valid_q;
  assign accept     = pose_valid && !pend_valid_q;
  // Accept and swap are mutually exclusive: accept needs an empty slot, swap a full one.
  assign swap       = frame_start && pend_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      pend_cos_q   <= '0;
      pend_sin_q   <= '0;
      pend_en_q    <= 1'b0;
      pend_key_q   <= 1'b0;
      act_x_q      <= '0;
      act_y_q      <= '0;
      act_cos_q    <= CosOne;
      act_sin_q    <= '0;
      act_en_q     <= 1'b0;
      act_key_q    <= 1'b0;
      applied_q    <= 1'b0;
    end else begin
      applied_q <= swap;
      if (accept) begin
        pend_valid_q <= 1'b1;
        pend_x_q     <= pose_x;
        pend_y_q     <= pose_y;
        pend_cos_q   <= pose_cos;
        pend_sin_q   <= pose_sin;
        pend_en_q    <= pose_en;
        pend_key_q   <= pose_key_en;
      end else if (swap) begin
        pend_valid_q <= 1'b0;
        act_x_q      <= pend_x_q;
        act_y_q      <= pend_y_q;
        act_cos_q    <= pend_cos_q;
        act_sin_q    <= pend_sin_q;
        act_en_q     <= pend_en_q;
        act_key_q    <= pend_key_q;
      end
    end
  end

  assign pose_applied = applied_q;

  // ---------------------------------------------------------------------------
  // Pixel pipeline
  // ---------------------------------------------------------------------------
  logic signed [11:0]      dx_q, dy_q;
  logic signed [TrigW-1:0] cos_s, sin_s;
  logic signed [ProdW-1:0] p_cdx_q, p_sdy_q, p_cdy_q, p_sdx_q;
  logic                    en_s2_q, key_s2_q;

  logic signed [SumW-1:0]  u_sum, v_sum, u_sh, v_sh;
  logic signed [31:0]      u_ext, v_ext;
  logic                    in_bounds_d;
  logic [p_addr_width-1:0] rom_addr_d;

  logic                    in_bounds_q, key_s3_q;
  logic [p_addr_width-1:0] rom_addr_q;

  logic                    ib_dly_q  [p_rom_latency];
  logic                    key_dly_q [p_rom_latency];
  logic                    draw_d, draw_q;
  logic [23:0]             rgb_q;

  assign cos_s = act_cos_q;
  assign sin_s = act_sin_q;

  // S3 combinational: rotate, floor-shift, bounds test and address
  always_comb begin
    u_sum = SumW'(p_cdx_q) + SumW'(p_sdy_q);
    v_sum = SumW'(p_cdy_q) - SumW'(p_sdx_q);
    u_sh  = u_sum >>> p_frac_bits;
    v_sh  = v_sum >>> p_frac_bits;
    u_ext = 32'(u_sh);
    v_ext = 32'(v_sh);
    in_bounds_d = en_s2_q && (u_ext >= 0) && (u_ext < WidthS) &&
                  (v_ext >= 0) && (v_ext < HeightS);
    rom_addr_d  = '0;
    if (in_bounds_d) begin
      rom_addr_d = p_addr_width'(u_ext) +
                   p_addr_width'(p_image_width) * p_addr_width'(v_ext);
    end
  end

  // Output: key-coloured texels are transparent only when key_en travelled with them
  assign draw_d = ib_dly_q[p_rom_latency-1] &&
                  !(key_dly_q[p_rom_latency-1] && (rom_q == p_key_color));

  always_ff @(posedge clk) begin
    if (reset) begin
      dx_q        <= '0;
      dy_q        <= '0;
      p_cdx_q     <= '0;
      p_sdy_q     <= '0;
      p_cdy_q     <= '0;
      p_sdx_q     <= '0;
      en_s2_q     <= 1'b0;
      key_s2_q    <= 1'b0;
      in_bounds_q <= 1'b0;
      key_s3_q    <= 1'b0;
      rom_addr_q  <= '0;
      for (int i = 0; i < int'(p_rom_latency); i++) begin
        ib_dly_q[i]  <= 1'b0;
        key_dly_q[i] <= 1'b0;
      end
      draw_q      <= 1'b0;
      rgb_q       <= '0;
    end else begin
      // S1: offset from the active origin
      dx_q        <= {1'b0, VGA_X} - {1'b0, act_x_q};
      dy_q        <= {1'b0, VGA_Y} - {1'b0, act_y_q};
      // S2: full-width products with the active trig values
      p_cdx_q     <= ProdW'(cos_s) * ProdW'(dx_q);
      p_sdy_q     <= ProdW'(sin_s) * ProdW'(dy_q);
      p_cdy_q     <= ProdW'(cos_s) * ProdW'(dy_q);
      p_sdx_q     <= ProdW'(sin_s) * ProdW'(dx_q);
      en_s2_q     <= act_en_q;
      key_s2_q    <= act_key_q;
      // S3
      in_bounds_q <= in_bounds_d;
      key_s3_q    <= key_s2_q;
      rom_addr_q  <= rom_addr_d;
      // Sideband delay matching the ROM read latency
      ib_dly_q[0]  <= in_bounds_q;
      key_dly_q[0] <= key_s3_q;
      for (int i = 1; i < int'(p_rom_latency); i++) begin
        ib_dly_q[i]  <= ib_dly_q[i-1];
        key_dly_q[i] <= key_dly_q[i-1];
      end
      draw_q      <= draw_d;
      rgb_q       <= draw_d ? rom_q : 24'h0;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign draw_image = draw_q;
  assign image_R    = rgb_q[23:16];
  assign image_G    = rgb_q[15:8];
  assign image_B    = rgb_q[7:0];

endmodule

// File: tb/tb_rotated_sprite_engine.sv
// Bench for rotated_sprite_engine (default parameters). A behavioural ROM with the
// configured latency feeds rom_q; every tracked scan pixel pushes its expected address
// and output to a scoreboard that is popped at the architectural latencies.

module tb_rotated_sprite_engine;

  localparam int W    = 80;
  localparam int H    = 480;
  localparam int FRAC = 8;
  localparam int L    = 2;
  localparam logic [23:0] KEY = 24'hFF00FF;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] VGA_X, VGA_Y;
  logic        frame_start, pose_valid, pose_ready;
  logic [10:0] pose_x, pose_y;
  logic [9:0]  pose_cos, pose_sin;
  logic        pose_en, pose_key_en;
  logic [15:0] rom_addr;
  logic [23:0] rom_q;
  logic        pose_applied, draw_image;
  logic [7:0]  image_R, image_G, image_B;

  always #5 clk = ~clk;

  rotated_sprite_engine dut (
    .clk(clk), .reset(reset), .VGA_X(VGA_X), .VGA_Y(VGA_Y),
    .frame_start(frame_start), .pose_valid(pose_valid), .pose_ready(pose_ready),
    .pose_x(pose_x), .pose_y(pose_y), .pose_cos(pose_cos), .pose_sin(pose_sin),
    .pose_en(pose_en), .pose_key_en(pose_key_en), .rom_addr(rom_addr), .rom_q(rom_q),
    .pose_applied(pose_applied), .draw_image(draw_image),
    .image_R(image_R), .image_G(image_G), .image_B(image_B)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ROM model: mode 0 constant, mode 1 key colour, mode 2 address-dependent
  int          rom_mode = 0;
  logic [15:0] rom_pipe [L];

  function automatic logic [23:0] rom_data(input int mode, input logic [15:0] a);
    if (mode == 0) return 24'h123456;
    if (mode == 1) return KEY;
    return {8'hC3, a};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < L; i++) rom_pipe[i] <= 16'd0;
    end else begin
      rom_pipe[0] <= rom_addr;
      for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
  end

  assign rom_q = rom_data(rom_mode, rom_pipe[L-1]);

  // Bench-side view of the active pose
  int m_x = 0, m_y = 0, m_c = 256, m_s = 0;
  bit m_en = 0, m_key = 0;

  typedef struct {
    logic [15:0] addr;
    logic        draw;
    logic [23:0] rgb;
  } exp_t;

  exp_t addr_q[$];
  exp_t out_q[$];

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    int dx, dy, u, v;
    logic ib;
    logic [23:0] d;
    dx = x - m_x;
    dy = y - m_y;
    u  = (m_c * dx + m_s * dy) >>> FRAC;
    v  = (m_c * dy - m_s * dx) >>> FRAC;
    ib = m_en && (u >= 0) && (u < W) && (v >= 0) && (v < H);
    e.addr = ib ? 16'(u + W * v) : 16'd0;
    d      = rom_data(rom_mode, e.addr);
    e.draw = ib && !(m_key && d == KEY);
    e.rgb  = e.draw ? d : 24'h0;
    return e;
  endfunction

  // Scoreboard monitor: tag_sr[k] marks a tracked pixel driven k cycles ago
  logic [15:0] tag_sr = '0;
  logic        cur_tag = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    tag_sr = {tag_sr[14:0], cur_tag};
    if (tag_sr[3]) begin
      n_cmp++;
      if (addr_q.size() == 0) begin
        n_err++;
        $display("FAIL rom_addr_sb: pixel arrived with empty queue, got %0d", rom_addr);
      end else begin
        e = addr_q.pop_front();
        if (rom_addr !== e.addr) begin
          n_err++;
          $display("FAIL rom_addr: got %0d expected %0d", rom_addr, e.addr);
        end
      end
    end
    if (tag_sr[4+L]) begin
      n_cmp += 2;
      if (out_q.size() == 0) begin
        n_err += 2;
        $display("FAIL out_sb: output arrived with empty queue");
      end else begin
        e = out_q.pop_front();
        if (draw_image !== e.draw) begin
          n_err++;
          $display("FAIL draw_image: got %b expected %b (addr %0d)", draw_image, e.draw,
                   e.addr);
        end
        if ({image_R, image_G, image_B} !== e.rgb) begin
          n_err++;
          $display("FAIL rgb: got %h expected %h (addr %0d)", {image_R, image_G, image_B},
                   e.rgb, e.addr);
        end
      end
    end
  end

  task automatic scan(input int x, input int y);
    exp_t e;
    @(posedge clk); #1;
    VGA_X = 11'(x);
    VGA_Y = 11'(y);
    cur_tag = 1'b1;
    e = model(x, y);
    addr_q.push_back(e);
    out_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cur_tag = 1'b0;
      VGA_X = '0;
      VGA_Y = '0;
    end
  endtask

  task automatic drive_pose(input int x, input int y, input int c, input int s,
                            input bit en, input bit key);
    pose_x = 11'(x); pose_y = 11'(y);
    pose_cos = 10'(c); pose_sin = 10'(s);
    pose_en = en; pose_key_en = key;
  endtask

  // Offer a pose, wait (bounded) for acceptance, then swap it in with frame_start
  task automatic load_pose(input int x, input int y, input int c, input int s,
                           input bit en, input bit key);
    int k;
    idle(1);
    drive_pose(x, y, c, s, en, key);
    pose_valid = 1'b1;
    k = 0;
    while (!pose_ready && k < 20) begin
      idle(1);
      k++;
    end
    if (k == 20) begin
      n_cmp++;
      n_err++;
      $display("FAIL load_pose: pose_ready stayed %b", pose_ready);
    end
    idle(1);
    pose_valid = 1'b0;
    frame_start = 1'b1;
    idle(1);
    frame_start = 1'b0;
    m_x = x; m_y = y; m_c = c; m_s = s; m_en = en; m_key = key;
    idle(3);
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_c = 256; m_s = 0; m_en = 0; m_key = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    @(negedge clk);
    n_cmp += 4;
    if (rom_addr !== 16'd0) begin
      n_err++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr);
    end
    if (draw_image !== 1'b0 || {image_R, image_G, image_B} !== 24'h0) begin
      n_err++; $display("FAIL reset_out: draw %b rgb %h expected 0/0", draw_image,
                        {image_R, image_G, image_B});
    end
    if (pose_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_pose_ready: got %b expected 1", pose_ready);
    end
    if (pose_applied !== 1'b0) begin
      n_err++; $display("FAIL reset_pose_applied: got %b expected 0", pose_applied);
    end
    idle(1);
    reset = 1'b0;
    model_reset();
    // Default pose is disabled: nothing may be drawn
    scan(0, 0);
    scan(5, 10);
    idle(8);
  endtask

  task automatic test_identity_bounds();
    rom_mode = 0;
    load_pose(300, 200, 256, 0, 1'b1, 1'b0);
    scan(305, 210);
    scan(300, 200);
    scan(379, 679);
    scan(380, 200);
    scan(299, 200);
    scan(310, 680);
    scan(310, 199);
    idle(8);
  endtask

  task automatic test_rot90();
    rom_mode = 2;
    load_pose(300, 200, 0, 256, 1'b1, 1'b0);
    scan(300, 210);
    scan(305, 200);
    scan(290, 250);
    scan(300, 200);
    idle(8);
  endtask

  task automatic test_color_key();
    rom_mode = 1;
    load_pose(300, 200, 256, 0, 1'b1, 1'b1);
    scan(305, 210);
    scan(320, 260);
    idle(8);
    load_pose(300, 200, 256, 0, 1'b1, 1'b0);
    scan(305, 210);
    idle(8);
    rom_mode = 0;
    load_pose(300, 200, 256, 0, 1'b1, 1'b1);
    scan(305, 210);
    idle(8);
  endtask

  task automatic test_angles();
    rom_mode = 2;
    load_pose(500, 300, 221, 128, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) scan(450 + $urandom_range(0, 150), 250 + $urandom_range(0, 300));
    idle(8);
    load_pose(200, 100, 181, -181, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) scan(150 + $urandom_range(0, 200), 50 + $urandom_range(0, 350));
    idle(8);
  endtask

  task automatic test_back_to_back();
    rom_mode = 2;
    load_pose(0, 0, 256, 0, 1'b1, 1'b0);
    for (int y = 477; y < 482; y++) begin
      for (int x = 60; x < 90; x++) scan(x, y);
    end
    idle(8);
  endtask

  task automatic test_handshake();
    rom_mode = 2;
    idle(1);
    drive_pose(100, 50, 256, 0, 1'b1, 1'b0);  // pose A
    pose_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (pose_ready !== 1'b1) begin
      n_err++; $display("FAIL hs_ready_empty: got %b expected 1", pose_ready);
    end
    idle(1);
    drive_pose(200, 100, 256, 0, 1'b1, 1'b0);  // pose B, must be held off
    @(negedge clk);
    n_cmp++;
    if (pose_ready !== 1'b0) begin
      n_err++; $display("FAIL hs_ready_full: got %b expected 0", pose_ready);
    end
    idle(1);
    @(negedge clk);
    n_cmp++;
    if (pose_ready !== 1'b0 || pose_applied !== 1'b0) begin
      n_err++; $display("FAIL hs_hold: ready %b applied %b expected 0/0", pose_ready,
                        pose_applied);
    end
    idle(1);
    frame_start = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (pose_applied !== 1'b0) begin
      n_err++; $display("FAIL hs_applied_early: got %b expected 0", pose_applied);
    end
    idle(1);
    frame_start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pose_applied !== 1'b1 || pose_ready !== 1'b1) begin
      n_err++; $display("FAIL hs_swap: applied %b ready %b expected 1/1", pose_applied,
                        pose_ready);
    end
    idle(1);  // B accepted on this edge
    pose_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pose_applied !== 1'b0 || pose_ready !== 1'b0) begin
      n_err++; $display("FAIL hs_b_pending: applied %b ready %b expected 0/0", pose_applied,
                        pose_ready);
    end
    m_x = 100; m_y = 50; m_c = 256; m_s = 0; m_en = 1; m_key = 0;
    idle(3);
    scan(110, 60);
    scan(205, 110);
    idle(8);
    frame_start = 1'b1;
    idle(1);
    frame_start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pose_applied !== 1'b1 || pose_ready !== 1'b1) begin
      n_err++; $display("FAIL hs_swap_b: applied %b ready %b expected 1/1", pose_applied,
                        pose_ready);
    end
    m_x = 200; m_y = 100;
    idle(3);
    frame_start = 1'b1;  // nothing pending
    idle(1);
    frame_start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pose_applied !== 1'b0) begin
      n_err++; $display("FAIL hs_empty_frame: pose_applied got %b expected 0", pose_applied);
    end
    idle(3);
    scan(110, 60);
    scan(205, 110);
    idle(8);
  endtask

  task automatic test_reset_midstream();
    rom_mode = 0;
    load_pose(300, 200, 256, 0, 1'b1, 1'b0);
    drive_pose(300, 200, 256, 0, 1'b1, 1'b0);
    pose_valid = 1'b1;  // leave a pose pending so reset has to discard it
    idle(1);
    pose_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      cur_tag = 1'b0;
      VGA_X = 11'(305 + i);
      VGA_Y = 11'd210;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp += 3;
    if (rom_addr !== 16'd0 || draw_image !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_out: addr %0d draw %b expected 0/0", rom_addr,
                        draw_image);
    end
    if ({image_R, image_G, image_B} !== 24'h0 || pose_applied !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_rgb: rgb %h applied %b expected 0/0",
                        {image_R, image_G, image_B}, pose_applied);
    end
    if (pose_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_reset_ready: got %b expected 1", pose_ready);
    end
    model_reset();
    frame_start = 1'b1;
    idle(1);
    frame_start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pose_applied !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_discard: pose_applied got %b expected 0",
                        pose_applied);
    end
    idle(3);
    scan(305, 210);
    scan(379, 679);
    scan(300, 200);
    idle(8);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    VGA_X = '0; VGA_Y = '0;
    frame_start = 1'b0;
    pose_valid = 1'b0;
    drive_pose(0, 0, 0, 0, 1'b0, 1'b0);
    test_reset();
    test_identity_bounds();
    test_rot90();
    test_color_key();
    test_angles();
    test_back_to_back();
    test_handshake();
    test_reset_midstream();
    idle(4);
    n_cmp++;
    if (addr_q.size() != 0 || out_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d/%0d entries left", addr_q.size(), out_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
